// File: rtl/pcie_framing_pkg.sv
// Framing K-symbols and framer FSM states shared by the transmit framer and the receive-side identifier.
// Pure declarations; no logic.
package pcie_framing_pkg;

   localparam logic [7:0] K_STP = 8'hFB;
   localparam logic [7:0] K_SDP = 8'h5C;
   localparam logic [7:0] K_END = 8'hFD;
   localparam logic [7:0] K_EDB = 8'hFE;
   localparam logic [7:0] K_PAD = 8'hF7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_TERM = 2'd2
   } frm_state_e;

endpackage

// File: rtl/symbol_packer.sv
// Packs single symbols into W-lane words; a word leaves on filling lane W-1 or on flush, one cycle after its last insert.
// One-deep output register; can_take_o/can_load_o tell the producer when an insert or a flush would be lost.
module symbol_packer #(
   parameter int W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sym_vld_i,
   input  logic [7:0]       sym_dat_i,
   input  logic             sym_k_i,
   input  logic             flush_i,
   output logic             can_take_o,
   output logic             can_load_o,
   output logic [8*W-1:0]   dat_o,
   output logic [W-1:0]     dk_o,
   output logic [W-1:0]     lane_vld_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic [CW-1:0]  cnt_q, cnt_d;
   logic [8*W-1:0] acc_dat_q, acc_dat_d;
   logic [W-1:0]   acc_k_q, acc_k_d;
   logic [W-1:0]   acc_v_q, acc_v_d;

   logic [8*W-1:0] out_dat_q, out_dat_d;
   logic [W-1:0]   out_k_q, out_k_d;
   logic [W-1:0]   out_v_q, out_v_d;
   logic           out_vld_q, out_vld_d;

   logic           complete;

   assign can_load_o = !out_vld_q || out_ready_i;
   assign can_take_o = (cnt_q != LAST) || can_load_o;

   always_comb begin
      cnt_d     = cnt_q;
      acc_dat_d = acc_dat_q;
      acc_k_d   = acc_k_q;
      acc_v_d   = acc_v_q;
      out_dat_d = out_dat_q;
      out_k_d   = out_k_q;
      out_v_d   = out_v_q;
      out_vld_d = out_vld_q;

      if (sym_vld_i) begin
         acc_dat_d[8*cnt_q +: 8] = sym_dat_i;
         acc_k_d[cnt_q]          = sym_k_i;
         acc_v_d[cnt_q]          = 1'b1;
      end

      // A flush on an empty accumulator (END landed in lane W-1) must not emit a blank word.
      complete = (sym_vld_i && (cnt_q == LAST)) || (flush_i && (acc_v_d != '0));

      if (out_vld_q && out_ready_i) begin
         out_vld_d = 1'b0;
         out_dat_d = '0;
         out_k_d   = '0;
         out_v_d   = '0;
      end

      if (complete) begin
         out_vld_d = 1'b1;
         out_dat_d = acc_dat_d;
         out_k_d   = acc_k_d;
         out_v_d   = acc_v_d;
         acc_dat_d = '0;
         acc_k_d   = '0;
         acc_v_d   = '0;
         cnt_d     = '0;
      end else if (sym_vld_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         acc_dat_q <= '0;
         acc_k_q   <= '0;
         acc_v_q   <= '0;
         out_dat_q <= '0;
         out_k_q   <= '0;
         out_v_q   <= '0;
         out_vld_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_dat_q <= acc_dat_d;
         acc_k_q   <= acc_k_d;
         acc_v_q   <= acc_v_d;
         out_dat_q <= out_dat_d;
         out_k_q   <= out_k_d;
         out_v_q   <= out_v_d;
         out_vld_q <= out_vld_d;
      end
   end

   assign dat_o       = out_dat_q;
   assign dk_o        = out_k_q;
   assign lane_vld_o  = out_v_q;
   assign out_valid_o = out_vld_q;

endmodule

// File: rtl/packet_framer.sv
// Wraps each byte-serial TLP/DLLP in STP/SDP ... END/EDB K-symbols and packs the result into W-lane words.
// Word visible one cycle after its last symbol; in_ready drops while the packer's last lane has nowhere to go.
module packet_framer
   import pcie_framing_pkg::*;
#(
   parameter int         W       = 4,
   parameter logic [7:0] STP_SYM = K_STP,
   parameter logic [7:0] SDP_SYM = K_SDP,
   parameter logic [7:0] END_SYM = K_END,
   parameter logic [7:0] EDB_SYM = K_EDB
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_sop,
   input  logic             in_eop,
   input  logic             in_dllp,
   input  logic             in_abort,
   output logic             in_ready,
   output logic [8*W-1:0]   Data_out,
   output logic [W-1:0]     DK,
   output logic [W-1:0]     valid,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             protocol_err
);

   frm_state_e state_q, state_d;
   logic       first_q, first_d;
   logic       abort_q, abort_d;
   logic       err_q, err_d;

   logic       sym_vld;
   logic [7:0] sym_dat;
   logic       sym_k;
   logic       flush;
   logic       can_take;
   logic       can_load;

   always_comb begin
      state_d  = state_q;
      first_d  = first_q;
      abort_d  = abort_q;
      err_d    = 1'b0;
      in_ready = 1'b0;
      sym_vld  = 1'b0;
      sym_dat  = 8'h00;
      sym_k    = 1'b0;
      flush    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The sop byte stays on the input; it is taken in DATA after the start symbol.
            if (in_valid && in_sop) begin
               if (can_take) begin
                  sym_vld = 1'b1;
                  sym_dat = in_dllp ? SDP_SYM : STP_SYM;
                  sym_k   = 1'b1;
                  first_d = 1'b1;
                  state_d = ST_DATA;
               end
            end else if (in_valid) begin
               in_ready = 1'b1;
               err_d    = 1'b1;
            end
         end
         ST_DATA: begin
            in_ready = can_take;
            if (in_valid && can_take) begin
               sym_vld = 1'b1;
               sym_dat = in_data;
               first_d = 1'b0;
               if (in_sop && !first_q) err_d = 1'b1;
               if (in_eop) begin
                  abort_d = in_abort;
                  state_d = ST_TERM;
               end
            end
         end
         ST_TERM: begin
            // The end symbol always completes a word, so it waits for room in the output register.
            if (can_load) begin
               sym_vld = 1'b1;
               sym_dat = abort_q ? EDB_SYM : END_SYM;
               sym_k   = 1'b1;
               flush   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (rst) in_ready = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         first_q <= 1'b0;
         abort_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         abort_q <= abort_d;
         err_q   <= err_d;
      end
   end

   assign protocol_err = err_q;

   symbol_packer #(
      .W (W)
   ) u_packer (
      .clk_i       (clk),
      .rst_i       (rst),
      .sym_vld_i   (sym_vld),
      .sym_dat_i   (sym_dat),
      .sym_k_i     (sym_k),
      .flush_i     (flush),
      .can_take_o  (can_take),
      .can_load_o  (can_load),
      .dat_o       (Data_out),
      .dk_o        (DK),
      .lane_vld_o  (valid),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
   );

endmodule

// File: tb/tb_packet_framer.sv
// Directed bench for packet_framer at W=4: framing, abort, backpressure, async reset, idle protocol error.
module tb_packet_framer;

   localparam int W = 4;

   typedef struct packed {
      logic [8*W-1:0] d;
      logic [W-1:0]   k;
      logic [W-1:0]   v;
   } word_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [7:0]     in_data = 8'h00;
   logic           in_valid = 1'b0;
   logic           in_sop = 1'b0;
   logic           in_eop = 1'b0;
   logic           in_dllp = 1'b0;
   logic           in_abort = 1'b0;
   logic           in_ready;
   logic [8*W-1:0] Data_out;
   logic [W-1:0]   DK;
   logic [W-1:0]   valid;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic           protocol_err;

   int    tests = 0;
   int    fails = 0;
   word_t got_q[$];
   word_t exp_q[$];
   logic [7:0] pkt [16];

   packet_framer #(.W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_sop       (in_sop),
      .in_eop       (in_eop),
      .in_dllp      (in_dllp),
      .in_abort     (in_abort),
      .in_ready     (in_ready),
      .Data_out     (Data_out),
      .DK           (DK),
      .valid        (valid),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) got_q.push_back({Data_out, DK, valid});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_pkt(input int len, input logic dllp, input logic abort);
      for (int i = 0; i < len; i++) begin
         logic got;
         int   budget;
         got = 1'b0;
         budget = 0;
         in_valid = 1'b1;
         in_data  = pkt[i];
         in_sop   = (i == 0);
         in_eop   = (i == len - 1);
         in_dllp  = dllp;
         in_abort = abort && (i == len - 1);
         while (!got && budget < 50) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            budget++;
         end
         if (!got) begin
            tests++;
            fails++;
            $display("FAIL send_timeout byte %0d: in_ready=0, required 1 within 50 cycles", i);
         end
      end
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_dllp  = 1'b0;
      in_abort = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      in_sop   = 1'b0;
      #2;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      tests++; if ({Data_out, DK, valid} !== '0) begin fails++; $display("FAIL reset_word: got %h/%b/%b required 0", Data_out, DK, valid); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
      tests++; if (protocol_err !== 1'b0) begin fails++; $display("FAIL reset_protocol_err: got %b required 0", protocol_err); end
      in_valid = 1'b0;
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_dllp();
      for (int i = 0; i < 6; i++) pkt[i] = 8'(8'hA0 + i);
      got_q.delete();
      exp_q.delete();
      out_ready = 1'b1;
      send_pkt(6, 1'b1, 1'b0);
      idle(4);
      exp_q.push_back({32'hA2A1A05C, 4'b0001, 4'b1111});
      exp_q.push_back({32'hFDA5A4A3, 4'b1000, 4'b1111});
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL dllp_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         tests++;
         if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL dllp_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_tlp_end();
      pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
      got_q.delete();
      exp_q.delete();
      send_pkt(3, 1'b0, 1'b0);
      idle(4);
      exp_q.push_back({32'h332211FB, 4'b0001, 4'b1111});
      exp_q.push_back({32'h000000FD, 4'b0001, 4'b0001});
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL tlp_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         tests++;
         if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL tlp_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_abort();
      pkt[0] = 8'hB0; pkt[1] = 8'hB1;
      got_q.delete();
      exp_q.delete();
      send_pkt(2, 1'b0, 1'b1);
      idle(4);
      exp_q.push_back({32'hFEB1B0FB, 4'b1001, 4'b1111});
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL abort_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         tests++;
         if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL abort_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic  stall_seen;
      logic  unstable;
      logic  vld_timeout;
      word_t held;
      for (int i = 0; i < 10; i++) pkt[i] = 8'(8'h10 + i);
      got_q.delete();
      exp_q.delete();
      stall_seen  = 1'b0;
      unstable    = 1'b0;
      vld_timeout = 1'b0;
      out_ready   = 1'b0;
      fork
         send_pkt(10, 1'b0, 1'b0);
         begin
            int b;
            b = 0;
            @(negedge clk);
            while (!out_valid && b < 40) begin
               @(negedge clk);
               b++;
            end
            if (!out_valid) vld_timeout = 1'b1;
            held = {Data_out, DK, valid};
            for (int c = 0; c < 5; c++) begin
               if (c > 0) @(negedge clk);
               if ({Data_out, DK, valid} !== held) unstable = 1'b1;
               if (!in_ready) stall_seen = 1'b1;
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      idle(5);
      tests++; if (vld_timeout !== 1'b0) begin fails++; $display("FAIL bp_out_valid_timeout: got %b required 0", vld_timeout); end
      tests++; if (stall_seen !== 1'b1) begin fails++; $display("FAIL bp_in_ready_drop: got %b required 1", stall_seen); end
      tests++; if (unstable !== 1'b0) begin fails++; $display("FAIL bp_held_stable: got %b required 0", unstable); end
      exp_q.push_back({32'h121110FB, 4'b0001, 4'b1111});
      exp_q.push_back({32'h16151413, 4'b0000, 4'b1111});
      exp_q.push_back({32'hFD191817, 4'b1000, 4'b1111});
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         tests++;
         if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int acc;
      int b;
      got_q.delete();
      exp_q.delete();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_dllp   = 1'b0;
      in_abort  = 1'b0;
      in_eop    = 1'b0;
      acc = 0;
      b   = 0;
      while (acc < 3 && b < 20) begin
         in_data = 8'(8'hD0 + acc);
         in_sop  = (acc == 0);
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk);
         #1;
         b++;
      end
      in_data = 8'hD3;
      in_sop  = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre_valid: got %b required 1", out_valid); end
      rst = 1'b1;
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
      tests++; if ({Data_out, DK, valid} !== '0) begin fails++; $display("FAIL rstmid_word: got %h/%b/%b required 0", Data_out, DK, valid); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_in_ready: got %b required 0", in_ready); end
      in_valid = 1'b0;
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      got_q.delete();
      out_ready = 1'b1;
      pkt[0] = 8'hC1; pkt[1] = 8'hC2;
      send_pkt(2, 1'b0, 1'b0);
      idle(4);
      exp_q.push_back({32'hFDC2C1FB, 4'b1001, 4'b1111});
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rstmid_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         tests++;
         if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rstmid_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      got_q.delete();
      exp_q.delete();
      pkt[0] = 8'h77;
      send_pkt(1, 1'b0, 1'b0);
      pkt[0] = 8'h88;
      send_pkt(1, 1'b1, 1'b0);
      idle(5);
      exp_q.push_back({32'h00FD77FB, 4'b0101, 4'b0111});
      exp_q.push_back({32'h00FD885C, 4'b0101, 4'b0111});
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         tests++;
         if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_word%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_idle_err();
      got_q.delete();
      in_valid = 1'b1;
      in_sop   = 1'b0;
      in_data  = 8'h55;
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_err_in_ready: got %b required 1", in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      tests++; if (protocol_err !== 1'b1) begin fails++; $display("FAIL idle_err_pulse: got %b required 1", protocol_err); end
      @(posedge clk);
      #1;
      tests++; if (protocol_err !== 1'b0) begin fails++; $display("FAIL idle_err_one_cycle: got %b required 0", protocol_err); end
      idle(4);
      tests++; if (got_q.size() != 0) begin fails++; $display("FAIL idle_err_no_word: got %0d words required 0", got_q.size()); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL idle_err_out_valid: got %b required 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_dllp();
      test_tlp_end();
      test_abort();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_idle_err();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
